// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants and state encoding for the 8-way round-robin output arbiter.
package mux_rr_pkg;

    localparam int unsigned N_REQ  = 8;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned DW     = 4;
    localparam int unsigned BEAT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester bundle plus shared valid/ready output channel of the arbiter.
interface mux_rr_arbiter_if;
    import mux_rr_pkg::*;

    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] data_in;
    logic                out_ready;
    logic                out_valid;
    logic [DW-1:0]       out_data;
    logic [SEL_W-1:0]    out_sel;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    req_ack;
    logic                busy;

    modport master (
        input  req, data_in, out_ready,
        output out_valid, out_data, out_sel, gnt, req_ack, busy
    );

    modport slave (
        output req, data_in, out_ready,
        input  out_valid, out_data, out_sel, gnt, req_ack, busy
    );

endinterface

// File: rtl/mux_rr_arbiter_pick.sv
// Rotating priority encoder: first set request scanning from ptr upward, wrapping 7->0.
module rr_priority_pick
    import mux_rr_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] j;

    always_comb begin
        any = 1'b0;
        idx = '0;
        j   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            j = ptr + SEL_W'(k);
            if (!any && req[j]) begin
                any = 1'b1;
                idx = j;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4-bit valid/ready channel among 8 requesters,
// with bursts of up to MAX_BURST beats and one idle bubble between grants.
module mux_rr_arbiter
    import mux_rr_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    mux_rr_arbiter_if.master  bus
);

    state_t             state, state_nx;
    logic [SEL_W-1:0]   ptr, ptr_nx;
    logic [SEL_W-1:0]   sel, sel_nx;
    logic [N_REQ-1:0]   gnt_q, gnt_nx;
    logic [BEAT_W-1:0]  beat, beat_nx;

    logic [DW-1:0]      lane [N_REQ];
    logic               pick_any;
    logic [SEL_W-1:0]   pick_idx;
    logic               sel_req, valid, xfer, rel;
    logic [N_REQ-1:0]   ack;

    rr_priority_pick u_pick (
        .req (bus.req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            lane[i] = bus.data_in[i*DW +: DW];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            sel   <= '0;
            gnt_q <= '0;
            beat  <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            sel   <= sel_nx;
            gnt_q <= gnt_nx;
            beat  <= beat_nx;
        end
    end

    // Handshake terms, shared by next-state and output logic
    always_comb begin
        sel_req = bus.req[sel];
        valid   = (state == GRANT) && sel_req;
        xfer    = valid && bus.out_ready;
        rel     = (state == GRANT) &&
                  (!sel_req || (xfer && (beat == BEAT_W'(MAX_BURST - 1))));
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        sel_nx   = sel;
        gnt_nx   = gnt_q;
        beat_nx  = beat;
        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nx = GRANT;
                    sel_nx   = pick_idx;
                    gnt_nx   = N_REQ'(1) << pick_idx;
                    beat_nx  = '0;
                end
            end
            GRANT: begin
                if (rel) begin
                    state_nx = IDLE;
                    ptr_nx   = sel + SEL_W'(1);
                    gnt_nx   = '0;
                    beat_nx  = '0;
                end else if (xfer) begin
                    beat_nx  = beat + BEAT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ack = '0;
        if (xfer) begin
            ack[sel] = 1'b1;
        end
        bus.out_valid = valid;
        bus.out_data  = valid ? lane[sel] : '0;
        bus.req_ack   = ack;
        bus.out_sel   = sel;
        bus.gnt       = gnt_q;
        bus.busy      = (state == GRANT);
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: per-cycle vector table, beat scoreboard,
// and hand sequences for backpressure, withdrawal and mid-grant reset.
module tb_mux_rr_arbiter;

    logic clk;
    logic rst;

    mux_rr_arbiter_if intf ();

    mux_rr_arbiter #(.MAX_BURST(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (intf.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] DATA_ALL = 32'h78fedcba;

    typedef struct {
        logic [7:0] req;
        logic       ready;
        logic       exp_valid;
        logic       exp_busy;
        logic [7:0] exp_gnt;
        logic [7:0] exp_ack;
        logic [3:0] exp_data;
    } vec_t;

    typedef struct {
        logic [2:0] idx;
        logic [3:0] data;
    } beat_t;

    vec_t   tbl [12];
    beat_t  sbq [$];
    logic   sb_en;
    int     n_vec;
    int     n_miss;
    int     acks;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        intf.req       = '0;
        intf.out_ready = 1'b1;
    endtask

    // Scoreboard: every accepted beat must match the next expected (requester, data).
    always @(negedge clk) begin
        if (sb_en && intf.out_valid && intf.out_ready) begin
            if (sbq.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL sb_extra_beat: got beat from %0d expected none", intf.out_sel);
            end else begin
                beat_t b;
                logic [7:0] oh;
                b  = sbq.pop_front();
                oh = 8'd1 << b.idx;
                check("sb_beat", {9'd0, intf.out_sel, intf.out_data, intf.req_ack, intf.gnt},
                      {9'd0, b.idx, b.data, oh, oh});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        n_vec  = 0;
        n_miss = 0;
        sb_en  = 1'b1;
        d      = DATA_ALL;

        // All-request grant order 0..7 then wrap to 0, four beats each
        for (int g = 0; g < 9; g++) begin
            for (int k = 0; k < 4; k++) begin
                beat_t b;
                b.idx  = 3'(g % 8);
                b.data = d[(g % 8)*4 +: 4];
                sbq.push_back(b);
            end
        end

        // Single requester 3 held: 4 beats, bubble, re-grant
        for (int r = 0; r < 12; r++) begin
            tbl[r].req   = 8'h08;
            tbl[r].ready = 1'b1;
            if (r % 5 == 0) begin
                tbl[r].exp_valid = 1'b0;
                tbl[r].exp_busy  = 1'b0;
                tbl[r].exp_gnt   = 8'h00;
                tbl[r].exp_ack   = 8'h00;
                tbl[r].exp_data  = 4'h0;
            end else begin
                tbl[r].exp_valid = 1'b1;
                tbl[r].exp_busy  = 1'b1;
                tbl[r].exp_gnt   = 8'h08;
                tbl[r].exp_ack   = 8'h08;
                tbl[r].exp_data  = 4'hd;
            end
        end

        // Reset held with everything requesting
        rst            = 1'b1;
        intf.req       = 8'hff;
        intf.data_in   = DATA_ALL;
        intf.out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("reset_outputs", {29'd0, intf.out_valid, intf.busy, |intf.gnt}, 32'd0);
            check("reset_gnt", {24'd0, intf.gnt}, 32'd0);
            tick();
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_idle", {23'd0, intf.out_valid, intf.gnt}, 32'd0);
        tick();
        @(negedge clk);
        check("first_grant", {21'd0, intf.out_sel, intf.gnt}, {21'd0, 3'd0, 8'h01});

        for (int c = 0; c < 80 && sbq.size() != 0; c++) begin
            tick();
            @(negedge clk);
        end
        check("sb_drained", sbq.size(), 32'd0);
        sb_en = 1'b0;
        intf.req = '0;

        do_reset();
        for (int r = 0; r < 12; r++) begin
            intf.req       = tbl[r].req;
            intf.out_ready = tbl[r].ready;
            @(negedge clk);
            check("tbl_single_req",
                  {10'd0, intf.out_valid, intf.busy, intf.gnt, intf.req_ack, intf.out_data},
                  {10'd0, tbl[r].exp_valid, tbl[r].exp_busy, tbl[r].exp_gnt,
                   tbl[r].exp_ack, tbl[r].exp_data});
            tick();
        end

        // Backpressure on requester 2 after two beats
        do_reset();
        acks = 0;
        intf.req = 8'h04;
        @(negedge clk);
        check("bp_idle", {31'd0, intf.out_valid}, 32'd0);
        for (int c = 0; c < 2; c++) begin
            tick();
            @(negedge clk);
            if (intf.req_ack[2]) acks++;
            check("bp_ack", {24'd0, intf.req_ack}, 32'h04);
        end
        tick();
        intf.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (intf.req_ack[2]) acks++;
            check("bp_stall", {19'd0, intf.out_valid, intf.out_data, intf.req_ack},
                  {19'd0, 1'b1, 4'hc, 8'h00});
            tick();
        end
        intf.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (intf.req_ack[2]) acks++;
            if (c == 2) check("bp_bubble", {23'd0, intf.out_valid, intf.gnt}, 32'd0);
            tick();
        end
        check("bp_burst_acks", acks, 32'd4);
        intf.req = '0;

        // Withdrawal by requester 5 after two acks, 2 and 6 arriving mid-grant
        do_reset();
        intf.req = 8'h20;
        @(negedge clk);
        tick();
        intf.req = 8'h64;
        @(negedge clk);
        check("wd_ack0", {24'd0, intf.req_ack}, 32'h20);
        tick();
        @(negedge clk);
        check("wd_ack1", {24'd0, intf.req_ack}, 32'h20);
        tick();
        intf.req = 8'h44;
        @(negedge clk);
        check("wd_drop", {14'd0, intf.out_valid, intf.req_ack, intf.gnt, intf.busy},
              {14'd0, 1'b0, 8'h00, 8'h20, 1'b1});
        tick();
        @(negedge clk);
        check("wd_bubble", {23'd0, intf.busy, intf.gnt}, 32'd0);
        tick();
        @(negedge clk);
        check("wd_next_grant", {13'd0, intf.out_sel, intf.gnt, intf.req_ack},
              {13'd0, 3'd6, 8'h40, 8'h40});
        tick();
        @(negedge clk);
        check("rg_beat1", {24'd0, intf.req_ack}, 32'h40);

        // Synchronous reset during beat 2 of the grant to 6
        tick();
        rst = 1'b1;
        @(negedge clk);
        tick();
        rst = 1'b0;
        intf.req = 8'h41;
        @(negedge clk);
        check("rg_idle", {22'd0, intf.out_valid, intf.busy, intf.gnt}, 32'd0);
        tick();
        @(negedge clk);
        check("rg_ptr_zero", {21'd0, intf.out_sel, intf.gnt}, {21'd0, 3'd0, 8'h01});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
